boot_reset_sequencer: RTL

- Sequences SoC reset release on the clk12 domain: stretches external reset, waits for stable PLL lock, then releases peripherals and the CPU in stages.
- Selects the CPU reset vector from the trimming_reset / trimming_reset_ena straps.
- Re-runs the sequence on watchdog request, software request or PLL lock loss, and records the cause.
- Sits between the board-level reset/strap inputs and the cram_soc core and peripheral reset nets.

---
 rtl/boot_seq_pkg.sv | 28 ++
 rtl/boot_reset_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/boot_seq_pkg.sv
// Shared types and constants for the boot reset sequencer: FSM states, reset-cause
// codes and the reset-vector alignment mask.
package boot_seq_pkg;

  typedef enum logic [1:0] {
    StHold      = 2'd0,
    StWaitLock  = 2'd1,
    StPeriphRel = 2'd2,
    StRun       = 2'd3
  } seq_state_e;

  localparam logic [1:0] CAUSE_EXT  = 2'b00;
  localparam logic [1:0] CAUSE_WDT  = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_LOCK = 2'b11;

  localparam logic [31:0] VEC_ALIGN_MASK = 32'hFFFF_FFFE;

  // Lock loss outranks watchdog, which outranks software.
  function automatic logic [1:0] cause_sel(input logic lock_lost, input logic wdt,
                                           input logic sw);
    if (lock_lost) return CAUSE_LOCK;
    else if (wdt)  return CAUSE_WDT;
    else if (sw)   return CAUSE_SW;
    else           return CAUSE_EXT;
  endfunction

endpackage

// File: rtl/boot_reset_sequencer.sv
// Staged SoC reset release on clk12: stretch, PLL-lock qualify, peripheral then CPU release.
// Optional macro TRIM_LOCK_EN: sample the trim reset vector only on the first boot after reset.
module boot_reset_sequencer
  import boot_seq_pkg::*;
#(
  parameter int unsigned RST_STRETCH    = 16,
  parameter int unsigned LOCK_STABLE    = 8,
  parameter int unsigned PERIPH_TO_CPU  = 4,
  parameter logic [31:0] DEFAULT_VECTOR = 32'h6000_0000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk12,
  input  logic        reset,
  input  logic [31:0] trimming_reset,
  input  logic        trimming_reset_ena,
  input  logic        pll_locked,
  input  logic        wdt_reset_req,
  input  logic        sw_reset_req,
  output logic        periph_rst,
  output logic        cpu_rst,
  output logic [31:0] cpu_reset_vector,
  output logic [1:0]  reset_cause,
  output logic        seq_done
);

  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(RST_STRETCH - 1);
  localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] PeriphLast = CNT_W'(PERIPH_TO_CPU - 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             periph_rst_q, cpu_rst_q, seq_done_q;
  logic [31:0]      vector_q;
  logic [1:0]       cause_q;
  logic             reentry;
  logic             vec_load_en;
  logic [31:0]      vec_sel;

  assign reentry = !pll_locked || wdt_reset_req || sw_reset_req;
  assign vec_sel = (trimming_reset_ena ? trimming_reset : DEFAULT_VECTOR) & VEC_ALIGN_MASK;

`ifdef TRIM_LOCK_EN
  logic trim_taken_q;
  assign vec_load_en = !trim_taken_q;

  always_ff @(posedge clk12) begin
    if (reset) begin
      trim_taken_q <= 1'b0;
    end else if (state_q == StWaitLock && pll_locked && cnt_q == LockLast) begin
      trim_taken_q <= 1'b1;
    end
  end
`else
  assign vec_load_en = 1'b1;
`endif

  always_ff @(posedge clk12) begin
    if (reset) begin
      state_q      <= StHold;
      cnt_q        <= '0;
      periph_rst_q <= 1'b1;
      cpu_rst_q    <= 1'b1;
      seq_done_q   <= 1'b0;
      vector_q     <= DEFAULT_VECTOR;
      cause_q      <= CAUSE_EXT;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == HoldLast) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          // Any lock drop restarts qualification; there is deliberately no timeout.
          if (!pll_locked) begin
            cnt_q <= '0;
          end else if (cnt_q == LockLast) begin
            state_q      <= StPeriphRel;
            cnt_q        <= '0;
            periph_rst_q <= 1'b0;
            if (vec_load_en) vector_q <= vec_sel;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPeriphRel, StRun: begin
          if (reentry) begin
            cause_q      <= cause_sel(!pll_locked, wdt_reset_req, sw_reset_req);
            state_q      <= StHold;
            cnt_q        <= '0;
            periph_rst_q <= 1'b1;
            cpu_rst_q    <= 1'b1;
            seq_done_q   <= 1'b0;
          end else if (state_q == StPeriphRel) begin
            if (cnt_q == PeriphLast) begin
              state_q    <= StRun;
              cnt_q      <= '0;
              cpu_rst_q  <= 1'b0;
              seq_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StHold;
      endcase
    end
  end

  assign periph_rst       = periph_rst_q;
  assign cpu_rst          = cpu_rst_q;
  assign seq_done         = seq_done_q;
  assign cpu_reset_vector = vector_q;
  assign reset_cause      = cause_q;

endmodule
